truth_table_scorer: RTL and testbench

Sequencer that scores a 4-input/4-output evolved gate-level candidate against a target truth table. On `start` it drives every input vector onto the candidate in order, waits a programmable settle window so the gate delays can propagate, and samples the outputs. It accumulates the number of correct output bits as the fitness score. The block sits between the evolution harness and the candidate netlist: the harness supplies the target table and reads back `score`/`err_mask`.

---
 rtl/evo_pkg.sv | 19 +
 rtl/bit_match_count.sv | 23 ++
 rtl/truth_table_scorer.sv | 126 ++++++++++++
 tb/tb_truth_table_scorer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/evo_pkg.sv
// Shared sizing constants and FSM state encoding for the candidate-scoring datapath.
// Pure declarations: no latency, no flow control.
package evo_pkg;

  localparam int N_IN    = 4;
  localparam int N_OUT   = 4;
  localparam int VECTORS = 1 << N_IN;
  localparam int TABLE_W = N_OUT * VECTORS;
  localparam int SCORE_W = $clog2(TABLE_W + 1);
  localparam int MATCH_W = $clog2(N_OUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/bit_match_count.sv
// Counts agreeing bits between candidate outputs and the expected slice.
// Purely combinational (zero latency); no backpressure.
module bit_match_count
  import evo_pkg::*;
(
  input  logic [N_OUT-1:0]   dut_out,
  input  logic [N_OUT-1:0]   expected,
  output logic [MATCH_W-1:0] match_cnt,
  output logic               mismatch
);

  logic [N_OUT-1:0] diff;

  always_comb begin
    diff      = dut_out ^ expected;
    match_cnt = '0;
    for (int j = 0; j < N_OUT; j++) begin
      match_cnt = match_cnt + MATCH_W'(~diff[j]);
    end
    mismatch  = |diff;
  end

endmodule

// File: rtl/truth_table_scorer.sv
// Sweeps all input vectors through a candidate netlist and scores it against a latched truth table.
// Latency VECTORS*(SETTLE_CYCLES+1) cycles from start to done; start ignored while busy, abort cancels.
module truth_table_scorer
  import evo_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [TABLE_W-1:0] target_table,
  output logic [N_IN-1:0]    dut_in,
  input  logic [N_OUT-1:0]   dut_out,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic [VECTORS-1:0] err_mask
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0]  LAST_VEC = N_IN'(VECTORS - 1);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [N_OUT-1:0]   table_q [VECTORS];
  logic [MATCH_W-1:0] match_cnt;
  logic               mismatch;
  logic               accept;

  assign accept = (state == IDLE) && start && !abort;

  bit_match_count u_match (
    .dut_out   (dut_out),
    .expected  (table_q[dut_in]),
    .match_cnt (match_cnt),
    .mismatch  (mismatch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nx = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (abort)           state_nx = IDLE;
        else if (cnt == '0)  state_nx = SAMPLE;
      end
      SAMPLE: begin
        busy = 1'b1;
        if (abort)                  state_nx = IDLE;
        else if (dut_in == LAST_VEC) state_nx = DONE;
        else                        state_nx = SETTLE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dut_in   <= '0;
      score    <= '0;
      err_mask <= '0;
      for (int v = 0; v < VECTORS; v++) table_q[v] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            for (int v = 0; v < VECTORS; v++) table_q[v] <= target_table[v*N_OUT +: N_OUT];
            score    <= '0;
            err_mask <= '0;
            dut_in   <= '0;
            cnt      <= CNT_LOAD;
          end
        end
        SETTLE: begin
          if (abort) begin
            score    <= '0;
            err_mask <= '0;
            dut_in   <= '0;
            cnt      <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            score    <= '0;
            err_mask <= '0;
            dut_in   <= '0;
            cnt      <= '0;
          end else begin
            score            <= score + SCORE_W'(match_cnt);
            err_mask[dut_in] <= mismatch;
            // Terminal test precedes the increment, so the index never wraps mid-sweep.
            if (dut_in != LAST_VEC) begin
              dut_in <= dut_in + 1'b1;
              cnt    <= CNT_LOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scorer.sv
// Scoreboard bench: three scorer instances (settle 8, 1, 12) driving behavioural candidates.
// Stimulus pushes expected results; per-instance monitors pop and compare on done.
module tb_truth_table_scorer;

  typedef struct {
    int          score;
    logic [15:0] mask;
    int          lat;
    bit          exact;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q_a[$];
  exp_t q_s1[$];
  exp_t q_s12[$];
  int   st_a = 0, st_s1 = 0, st_s12 = 0;

  logic        start_a = 1'b0, start_s1 = 1'b0, start_s12 = 1'b0;
  logic        abort_a = 1'b0, abort_s = 1'b0;
  logic [63:0] tt_a = '0, tt_s = '0;
  logic        cand_zero = 1'b0;

  logic [3:0]  in_a, in_s1, in_s12;
  wire  [3:0]  out_a, out_s1, out_s12;
  logic        busy_a, busy_s1, busy_s12;
  logic        done_a, done_s1, done_s12;
  logic [6:0]  score_a, score_s1, score_s12;
  logic [15:0] mask_a, mask_s1, mask_s12;

  assign #50   out_a   = cand_zero ? 4'h0 : in_a;
  assign #1000 out_s1  = in_s1;
  assign #1000 out_s12 = in_s12;

  truth_table_scorer #(.SETTLE_CYCLES(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .target_table(tt_a),
    .dut_in(in_a), .dut_out(out_a), .busy(busy_a), .done(done_a),
    .score(score_a), .err_mask(mask_a)
  );

  truth_table_scorer #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_s1), .abort(abort_s), .target_table(tt_s),
    .dut_in(in_s1), .dut_out(out_s1), .busy(busy_s1), .done(done_s1),
    .score(score_s1), .err_mask(mask_s1)
  );

  truth_table_scorer #(.SETTLE_CYCLES(12)) u_s12 (
    .clk(clk), .rst_n(rst_n), .start(start_s12), .abort(abort_s), .target_table(tt_s),
    .dut_in(in_s12), .dut_out(out_s12), .busy(busy_s12), .done(done_s12),
    .score(score_s12), .err_mask(mask_s12)
  );

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ident();
    logic [63:0] t;
    t = '0;
    for (int v = 0; v < 16; v++) t[v*4 +: 4] = 4'(v);
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic judge(input string tag, input exp_t e, input logic [6:0] sc,
                       input logic [15:0] m, input int lat, input logic [3:0] din);
    if (e.exact) begin
      chk({tag, " score"}, 64'(sc), 64'(e.score));
      chk({tag, " err_mask"}, 64'(m), 64'(e.mask));
    end else begin
      chk({tag, " stale score below 64"}, 64'(sc < 7'd64), 64'd1);
      chk({tag, " stale err_mask nonzero"}, 64'(m != 16'h0), 64'd1);
    end
    chk({tag, " done latency"}, 64'(lat), 64'(e.lat));
    chk({tag, " final dut_in"}, 64'(din), 64'hF);
  endtask

  task automatic unexpected_done(input string tag);
    checks++;
    errors++;
    $display("FAIL %s unexpected done: got done=1 with no sweep pending, expected 0", tag);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (done_a) begin
      if (q_a.size() == 0) unexpected_done("a");
      else begin
        e = q_a.pop_front();
        judge("a", e, score_a, mask_a, cyc - st_a, in_a);
      end
    end
  end

  always @(negedge clk) begin : mon_s1
    exp_t e;
    if (done_s1) begin
      if (q_s1.size() == 0) unexpected_done("s1");
      else begin
        e = q_s1.pop_front();
        judge("s1", e, score_s1, mask_s1, cyc - st_s1, in_s1);
      end
    end
  end

  always @(negedge clk) begin : mon_s12
    exp_t e;
    if (done_s12) begin
      if (q_s12.size() == 0) unexpected_done("s12");
      else begin
        e = q_s12.pop_front();
        judge("s12", e, score_s12, mask_s12, cyc - st_s12, in_s12);
      end
    end
  end

  // Start is presented for one cycle; the accepting edge becomes latency reference 0.
  task automatic go(input int which);
    @(negedge clk);
    case (which)
      0: start_a = 1'b1;
      1: start_s1 = 1'b1;
      default: start_s12 = 1'b1;
    endcase
    @(negedge clk);
    start_a = 1'b0; start_s1 = 1'b0; start_s12 = 1'b0;
    case (which)
      0: st_a = cyc;
      1: st_s1 = cyc;
      default: st_s12 = cyc;
    endcase
  endtask

  task automatic expect_a(input int sc, input logic [15:0] m);
    exp_t e;
    e.score = sc; e.mask = m; e.lat = 144; e.exact = 1'b1;
    q_a.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q_a.size() + q_s1.size() + q_s12.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if ((q_a.size() + q_s1.size() + q_s12.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: %0d results pending after %0d cycles, expected 0",
               q_a.size() + q_s1.size() + q_s12.size(), n);
      q_a.delete(); q_s1.delete(); q_s12.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    logic [63:0] t;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset score", 64'(score_a), 64'd0);
    chk("reset err_mask", 64'(mask_a), 64'd0);
    chk("reset dut_in", 64'(in_a), 64'd0);
    chk("reset busy", 64'(busy_a), 64'd0);
    chk("reset done", 64'(done_a), 64'd0);

    // Identity candidate against identity target.
    tt_a = ident();
    expect_a(64, 16'h0000);
    go(0);
    drain(400);

    // Candidate tied low: only vector 0 matches fully; 32 one-bits are missed.
    cand_zero = 1'b1;
    expect_a(32, 16'hFFFE);
    go(0);
    drain(400);
    cand_zero = 1'b0;

    // Vector 5 expectation inverted: 4 bits lost, only mask bit 5 set.
    t = ident();
    t[20 +: 4] = 4'hA;
    tt_a = t;
    expect_a(60, 16'h0020);
    go(0);
    drain(400);

    // Abort mid-sweep: no done, everything cleared the following cycle.
    tt_a = ident();
    go(0);
    repeat (49) @(negedge clk);
    chk("abort pre busy", 64'(busy_a), 64'd1);
    chk("abort pre score nonzero", 64'(score_a != 7'd0), 64'd1);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort busy", 64'(busy_a), 64'd0);
    chk("abort score", 64'(score_a), 64'd0);
    chk("abort err_mask", 64'(mask_a), 64'd0);
    chk("abort dut_in", 64'(in_a), 64'd0);
    repeat (200) @(negedge clk);
    expect_a(64, 16'h0000);
    go(0);
    drain(400);

    // Restart attempt and table change during a sweep must be ignored.
    expect_a(64, 16'h0000);
    go(0);
    repeat (19) @(negedge clk);
    start_a = 1'b1;
    tt_a = ~ident();
    @(negedge clk);
    start_a = 1'b0;
    drain(400);
    tt_a = ident();

    // Slow candidate: settle 1 samples stale outputs, settle 12 is long enough.
    tt_s = ident();
    e.score = 0; e.mask = 16'h0; e.lat = 32; e.exact = 1'b0;
    q_s1.push_back(e);
    go(1);
    drain(400);
    e.score = 64; e.mask = 16'h0; e.lat = 208; e.exact = 1'b1;
    q_s12.push_back(e);
    go(2);
    drain(600);

    // Asynchronous reset between edges in the middle of SETTLE.
    go(0);
    repeat (30) @(negedge clk);
    chk("pre-reset busy", 64'(busy_a), 64'd1);
    @(posedge clk);
    #20 rst_n = 1'b0;
    #1;
    chk("async reset busy", 64'(busy_a), 64'd0);
    chk("async reset done", 64'(done_a), 64'd0);
    chk("async reset score", 64'(score_a), 64'd0);
    chk("async reset err_mask", 64'(mask_a), 64'd0);
    chk("async reset dut_in", 64'(in_a), 64'd0);
    #10 rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("post reset busy", 64'(busy_a), 64'd0);

    // Block is back in IDLE and runs a clean sweep.
    expect_a(64, 16'h0000);
    go(0);
    drain(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
